// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: ALU ops, opcodes/functs,
// FSM state codes, datapath mux selects and decoded instruction classes.
package mc_ctrl_pkg;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_SUBU = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_EQL  = 5'd4;
  localparam logic [4:0] ALU_LUI  = 5'd5;
  localparam logic [4:0] ALU_ADD  = 5'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_OR    = 6'h25;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CLS_LW, CLS_SW, CLS_R, CLS_ORI, CLS_LUI, CLS_BEQ, CLS_J, CLS_ILL
  } iclass_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: Op/Funct -> instruction class, R-type ALU op
// and legal flag. An R-type with an unknown funct is classed illegal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    cls_o,
  output logic [4:0] r_aluop_o,
  output logic       legal_o
);

  logic r_ok;

  always_comb begin
    r_aluop_o = ALU_NOP;
    r_ok      = 1'b1;
    case (funct_i)
      FN_ADDU: r_aluop_o = ALU_ADDU;
      FN_SUBU: r_aluop_o = ALU_SUBU;
      FN_ADD:  r_aluop_o = ALU_ADD;
      FN_OR:   r_aluop_o = ALU_OR;
      default: r_ok      = 1'b0;
    endcase
  end

  always_comb begin
    cls_o = CLS_ILL;
    case (op_i)
      OP_RTYPE: cls_o = r_ok ? CLS_R : CLS_ILL;
      OP_LW:    cls_o = CLS_LW;
      OP_SW:    cls_o = CLS_SW;
      OP_ORI:   cls_o = CLS_ORI;
      OP_LUI:   cls_o = CLS_LUI;
      OP_BEQ:   cls_o = CLS_BEQ;
      OP_J:     cls_o = CLS_J;
      default:  cls_o = CLS_ILL;
    endcase
  end

  assign legal_o = (cls_o != CLS_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter; outputs decode
// combinationally from state. MC_CTRL_ILLEGAL_TRAP_EN: illegal ops park in TRAP.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic [1:0]         PCSource,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               EXTOp,
  output logic [4:0]         ALUOp,
  output logic [STATE_W-1:0] state_o,
  output logic [31:0]        instr_cnt,
  output logic               illegal
);

  state_e      state_q, state_d;
  logic [31:0] instr_cnt_q;
  iclass_e     cls;
  logic [4:0]  r_aluop;
  logic        legal;
  logic        retire;

  mc_ctrl_decode u_decode (
    .op_i      (Op),
    .funct_i   (Funct),
    .cls_o     (cls),
    .r_aluop_o (r_aluop),
    .legal_o   (legal)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_LW, CLS_SW:   state_d = S_MEMADR;
          CLS_R:            state_d = S_EXEC;
          CLS_ORI, CLS_LUI: state_d = S_IEXEC;
          CLS_BEQ:          state_d = S_BRANCH;
          CLS_J:            state_d = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:          state_d = S_TRAP;
`else
          default:          state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_d = (cls == CLS_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWR) || (state_q == S_RWB) ||
                  (state_q == S_IWB)   || (state_q == S_BRANCH) || (state_q == S_JUMP);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= 32'd0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      if (state_d == S_TRAP) illegal_q <= 1'b1;
`endif
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign state_o   = STATE_W'(state_q);

  always_comb begin
    PCWrite  = 1'b0;
    PCSource = PCSRC_ALU;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = REGDST_RT;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    EXTOp    = 1'b0;
    ALUOp    = ALU_NOP;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = SRCB_4;
        ALUOp   = ALU_ADDU;
        PCWrite = 1'b1;
      end
      // Speculatively compute the branch target into ALUOut.
      S_DECODE: begin
        ALUSrcB = SRCB_BR;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADDU;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = r_aluop;
      end
      S_RWB: begin
        RegDst   = REGDST_RD;
        RegWrite = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = (cls == CLS_LUI) ? ALU_LUI : ALU_OR;
      end
      S_IWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_EQL;
        PCSource = PCSRC_ALUOUT;
        PCWrite  = Zero;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // legal is only observed through cls; kept on the decoder for other consumers.
  logic unused_legal;
  assign unused_legal = legal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven check of the mc_ctrl FSM, outputs and counter.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  Op, Funct;
  logic        Zero;
  logic        PCWrite, IorD, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, EXTOp;
  logic [1:0]  PCSource, RegDst, ALUSrcB;
  logic [4:0]  ALUOp;
  logic [3:0]  state_o;
  logic [31:0] instr_cnt;
  logic        illegal;

  always #5 clk = ~clk;

  mc_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .PCSource(PCSource), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp),
    .state_o(state_o), .instr_cnt(instr_cnt), .illegal(illegal)
  );

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  st;
    logic [18:0] ctl;
    logic [31:0] cnt;
    logic        ill;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  // {PCWrite,PCSource,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,EXTOp,ALUOp}
  function automatic logic [18:0] mk(input logic pcw, input logic [1:0] pcs, input logic iord,
                                     input logic mw, input logic irw, input logic [1:0] rd,
                                     input logic m2r, input logic rw, input logic sa,
                                     input logic [1:0] sb, input logic ext, input logic [4:0] op);
    return {pcw, pcs, iord, mw, irw, rd, m2r, rw, sa, sb, ext, op};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [3:0] st, input logic [18:0] ctl, input logic [31:0] cnt,
                     input logic ill);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.z = z; v.st = st; v.ctl = ctl; v.cnt = cnt; v.ill = ill;
    vq.push_back(v);
  endtask

  task automatic step(input vec_t v, input int idx);
    logic [18:0] act;
    @(negedge clk);
    rst = v.r; Op = v.op; Funct = v.fn; Zero = v.z;
    #1;
    act = {PCWrite, PCSource, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, EXTOp, ALUOp};
    total++;
    if (state_o !== v.st) begin
      bad++;
      $display("FAIL state row %0d: got %0d want %0d", idx, state_o, v.st);
    end
    total++;
    if (act !== v.ctl) begin
      bad++;
      $display("FAIL ctrl row %0d: got %05h want %05h", idx, act, v.ctl);
    end
    total++;
    if (instr_cnt !== v.cnt) begin
      bad++;
      $display("FAIL instr_cnt row %0d: got %0d want %0d", idx, instr_cnt, v.cnt);
    end
    total++;
    if (illegal !== v.ill) begin
      bad++;
      $display("FAIL illegal row %0d: got %0b want %0b", idx, illegal, v.ill);
    end
  endtask

  logic [18:0] F, FR, D, MA, MR, MWB, MWR, RWB, IWB, J, Z0;
  vec_t tv;

  initial begin
    F   = mk(1, 2'd0, 0, 0, 1, 2'd0, 0, 0, 0, 2'd1, 0, 5'd1);
    FR  = mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd1, 0, 5'd1);
    D   = mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd3, 1, 5'd1);
    MA  = mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 1, 5'd6);
    MR  = mk(0, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 5'd0);
    MWB = mk(0, 2'd0, 0, 0, 0, 2'd0, 1, 1, 0, 2'd0, 0, 5'd0);
    MWR = mk(0, 2'd0, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 5'd0);
    RWB = mk(0, 2'd0, 0, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 5'd0);
    IWB = mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 5'd0);
    J   = mk(1, 2'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 5'd0);
    Z0  = 19'd0;

    // reset held: FETCH with enables masked
    add(1, 6'h23, 0, 0, 4'd0, FR, 0, 0);
    // lw
    add(0, 6'h23, 0, 0, 4'd0, F, 0, 0);
    add(0, 6'h23, 0, 0, 4'd1, D, 0, 0);
    add(0, 6'h23, 0, 0, 4'd2, MA, 0, 0);
    add(0, 6'h23, 0, 0, 4'd3, MR, 0, 0);
    add(0, 6'h23, 0, 0, 4'd4, MWB, 0, 0);
    // R-type subu / or / add / addu
    add(0, 6'h00, 6'h23, 0, 4'd0, F, 1, 0);
    add(0, 6'h00, 6'h23, 0, 4'd1, D, 1, 0);
    add(0, 6'h00, 6'h23, 0, 4'd6, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd2), 1, 0);
    add(0, 6'h00, 6'h23, 0, 4'd7, RWB, 1, 0);
    add(0, 6'h00, 6'h25, 0, 4'd0, F, 2, 0);
    add(0, 6'h00, 6'h25, 0, 4'd1, D, 2, 0);
    add(0, 6'h00, 6'h25, 0, 4'd6, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd3), 2, 0);
    add(0, 6'h00, 6'h25, 0, 4'd7, RWB, 2, 0);
    add(0, 6'h00, 6'h20, 0, 4'd0, F, 3, 0);
    add(0, 6'h00, 6'h20, 0, 4'd1, D, 3, 0);
    add(0, 6'h00, 6'h20, 0, 4'd6, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd6), 3, 0);
    add(0, 6'h00, 6'h20, 0, 4'd7, RWB, 3, 0);
    add(0, 6'h00, 6'h21, 0, 4'd0, F, 4, 0);
    add(0, 6'h00, 6'h21, 0, 4'd1, D, 4, 0);
    add(0, 6'h00, 6'h21, 0, 4'd6, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd1), 4, 0);
    add(0, 6'h00, 6'h21, 0, 4'd7, RWB, 4, 0);
    // sw
    add(0, 6'h2B, 0, 0, 4'd0, F, 5, 0);
    add(0, 6'h2B, 0, 0, 4'd1, D, 5, 0);
    add(0, 6'h2B, 0, 0, 4'd2, MA, 5, 0);
    add(0, 6'h2B, 0, 0, 4'd5, MWR, 5, 0);
    // beq taken, then not taken
    add(0, 6'h04, 0, 1, 4'd0, F, 6, 0);
    add(0, 6'h04, 0, 1, 4'd1, D, 6, 0);
    add(0, 6'h04, 0, 1, 4'd8, mk(1, 2'd1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd4), 6, 0);
    add(0, 6'h04, 0, 0, 4'd0, F, 7, 0);
    add(0, 6'h04, 0, 0, 4'd1, D, 7, 0);
    add(0, 6'h04, 0, 0, 4'd8, mk(0, 2'd1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd4), 7, 0);
    // lui, ori
    add(0, 6'h0F, 0, 0, 4'd0, F, 8, 0);
    add(0, 6'h0F, 0, 0, 4'd1, D, 8, 0);
    add(0, 6'h0F, 0, 0, 4'd10, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 5'd5), 8, 0);
    add(0, 6'h0F, 0, 0, 4'd11, IWB, 8, 0);
    add(0, 6'h0D, 0, 0, 4'd0, F, 9, 0);
    add(0, 6'h0D, 0, 0, 4'd1, D, 9, 0);
    add(0, 6'h0D, 0, 0, 4'd10, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 5'd3), 9, 0);
    add(0, 6'h0D, 0, 0, 4'd11, IWB, 9, 0);
    // j
    add(0, 6'h02, 0, 0, 4'd0, F, 10, 0);
    add(0, 6'h02, 0, 0, 4'd1, D, 10, 0);
    add(0, 6'h02, 0, 0, 4'd9, J, 10, 0);
    // reset during MEMRD of a lw: abandoned, counter cleared
    add(0, 6'h23, 0, 0, 4'd0, F, 11, 0);
    add(0, 6'h23, 0, 0, 4'd1, D, 11, 0);
    add(0, 6'h23, 0, 0, 4'd2, MA, 11, 0);
    add(1, 6'h23, 0, 0, 4'd3, MR, 11, 0);
    // reset during MEMWR of a sw: MemWrite masked
    add(0, 6'h2B, 0, 0, 4'd0, F, 0, 0);
    add(0, 6'h2B, 0, 0, 4'd1, D, 0, 0);
    add(0, 6'h2B, 0, 0, 4'd2, MA, 0, 0);
    add(1, 6'h2B, 0, 0, 4'd5, MR, 0, 0);
    // j after reset counts from zero
    add(0, 6'h02, 0, 0, 4'd0, F, 0, 0);
    add(0, 6'h02, 0, 0, 4'd1, D, 0, 0);
    add(0, 6'h02, 0, 0, 4'd9, J, 0, 0);
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    // illegal funct and opcode behave as 2-cycle uncounted NOPs
    add(0, 6'h00, 6'h3F, 0, 4'd0, F, 1, 0);
    add(0, 6'h00, 6'h3F, 0, 4'd1, D, 1, 0);
    add(0, 6'h3F, 0, 0, 4'd0, F, 1, 0);
    add(0, 6'h3F, 0, 0, 4'd1, D, 1, 0);
    add(0, 6'h02, 0, 0, 4'd0, F, 1, 0);
`endif

    rst = 1'b1; Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
    @(posedge clk);
    foreach (vq[i]) step(vq[i], i);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    // illegal opcode parks in TRAP with enables low until reset
    tv.r = 0; tv.op = 6'h3F; tv.fn = 0; tv.z = 0; tv.cnt = 1; tv.ill = 0;
    tv.st = 4'd0; tv.ctl = F; step(tv, 1000);
    tv.st = 4'd1; tv.ctl = D; step(tv, 1001);
    tv.z = 1; tv.op = 6'h02;
    for (int k = 0; k < 10; k++) begin
      tv.st = 4'd12; tv.ctl = Z0; tv.ill = 1;
      step(tv, 1002 + k);
    end
    tv.r = 1; step(tv, 1012);
    tv.r = 0; tv.z = 0; tv.st = 4'd0; tv.ctl = F; tv.cnt = 0; tv.ill = 0;
    step(tv, 1013);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
